// File: rtl/handshake_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared resource,
// with a start/done handshake, a saturating watchdog and a level-sensitive release.
module handshake_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      res_start,
    input  logic                      res_done,
    output logic                      busy,
    output logic                      timeout
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } stateType;

    stateType         state;
    stateType         stateNext;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   candidate;
    logic             found;
    logic [CW-1:0]    count;
    logic             watchdogExpired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Round-robin search starts one past the last released grantee and wraps.
    always_comb begin
        winner    = '0;
        candidate = '0;
        found     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            candidate = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[candidate]) begin
                found  = 1'b1;
                winner = candidate;
            end
        end
        watchdogExpired = (count == CW'(TIMEOUT - 1));

        stateNext = state;
        case (state)
            IDLE:    if (found) stateNext = GRANT;
            GRANT:   stateNext = BUSY;
            BUSY:    if (res_done || watchdogExpired) stateNext = RELEASE;
            RELEASE: if (!req[gnt_id]) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        res_start = (state == GRANT);
        busy      = (state != IDLE);
    end

    // Registered outputs, watchdog count and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            gnt_id  <= '0;
            timeout <= 1'b0;
            count   <= '0;
            ptr     <= IDW'(NREQ - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= NREQ'(1) << winner;
                        gnt_id <= winner;
                    end
                end
                GRANT: begin
                    count <= '0;
                end
                BUSY: begin
                    // res_done takes priority over an expiring watchdog.
                    if (!res_done) begin
                        if (count != CW'(TIMEOUT)) count <= count + CW'(1);
                        if (watchdogExpired) timeout <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!req[gnt_id]) begin
                        gnt <= '0;
                        ptr <= gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Self-checking bench for handshake_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_handshake_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gntId;
    logic            resStart;
    logic            resDone;
    logic            busy;
    logic            timeout;

    int checks   = 0;
    int failures = 0;

    handshake_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gntId),
        .res_start (resStart),
        .res_done  (resDone),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       start;
        logic       busy;
        logic       to;
    } vecType;

    vecType vecs[12];

    // Reference model: owner (-1 = none), edges since grant, release phase flag.
    int mOwner, mLast, mPtr, mAge;
    bit mWait, mTo;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mOwner = -1;
        mLast  = 0;
        mPtr   = NREQ - 1;
        mAge   = 0;
        mWait  = 0;
        mTo    = 0;
    endtask

    task automatic modelStep(input logic [3:0] r, input logic d);
        bit hit;
        mTo = 0;
        hit = 0;
        if (mOwner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (mPtr + k) % NREQ;
                if (!hit && r[c]) begin
                    hit    = 1;
                    mOwner = c;
                    mLast  = c;
                    mAge   = 0;
                    mWait  = 0;
                end
            end
        end else if (!mWait) begin
            mAge++;
            if (mAge >= 2) begin
                if (d) begin
                    mWait = 1;
                end else if (mAge - 1 == TIMEOUT) begin
                    mWait = 1;
                    mTo   = 1;
                end
            end
        end else if (!r[mOwner]) begin
            mPtr   = mOwner;
            mOwner = -1;
        end
    endtask

    task automatic modelCompare();
        chk("rand_gnt",   int'(gnt),      (mOwner >= 0) ? (1 << mOwner) : 0);
        chk("rand_id",    int'(gntId),    mLast);
        chk("rand_start", int'(resStart), (mOwner >= 0 && mAge == 0) ? 1 : 0);
        chk("rand_busy",  int'(busy),     (mOwner >= 0) ? 1 : 0);
        chk("rand_to",    int'(timeout),  int'(mTo));
    endtask

    task automatic checkAllZero(input string name);
        chk({name, "_gnt"},   int'(gnt),      0);
        chk({name, "_id"},    int'(gntId),    0);
        chk({name, "_start"}, int'(resStart), 0);
        chk({name, "_busy"},  int'(busy),     0);
        chk({name, "_to"},    int'(timeout),  0);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        req     = '0;
        resDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        rst     = 1'b0;
        req     = '0;
        resDone = 1'b0;

        //            req      done  gnt      id     start busy to
        vecs[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1010, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};

        doReset();
        for (int i = 0; i < 12; i++) begin
            req     = vecs[i].req;
            resDone = vecs[i].done;
            tick();
            chk($sformatf("vec%0d_gnt", i),   int'(gnt),      int'(vecs[i].gnt));
            chk($sformatf("vec%0d_id", i),    int'(gntId),    int'(vecs[i].id));
            chk($sformatf("vec%0d_start", i), int'(resStart), int'(vecs[i].start));
            chk($sformatf("vec%0d_busy", i),  int'(busy),     int'(vecs[i].busy));
            chk($sformatf("vec%0d_to", i),    int'(timeout),  int'(vecs[i].to));
        end

        // Round-robin order with all requesters active.
        doReset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int id;
            seen = 0;
            for (int w = 0; w < 10 && !seen; w++) begin
                tick();
                if (resStart) seen = 1;
            end
            chk("rr_start_seen", seen, 1);
            chk("rr_order", int'(gntId), n % NREQ);
            id = int'(gntId);
            tick();
            tick();
            resDone = 1'b1;
            tick();
            resDone = 1'b0;
            req[id] = 1'b0;
            tick();
            chk("rr_gap_gnt", int'(gnt), 0);
            req[id] = 1'b1;
        end

        // Watchdog expiry: pulse 16 edges after entering BUSY, grant held until req drops.
        doReset();
        req = 4'b0001;
        tick();
        chk("to_start", int'(resStart), 1);
        tick();
        seen = 0;
        for (int k = 1; k <= 40 && seen == 0; k++) begin
            tick();
            if (timeout) seen = k;
        end
        chk("to_latency", seen, TIMEOUT);
        tick();
        chk("to_pulse_width", int'(timeout), 0);
        chk("to_gnt_held", int'(gnt), 1);
        tick();
        chk("to_gnt_held2", int'(gnt), 1);
        req = 4'b0000;
        tick();
        chk("to_release", int'(gnt), 0);

        // res_done on the final watchdog cycle wins.
        doReset();
        req = 4'b0001;
        tick();
        tick();
        repeat (TIMEOUT - 1) tick();
        resDone = 1'b1;
        tick();
        resDone = 1'b0;
        chk("sim_to_low", int'(timeout), 0);
        chk("sim_gnt_held", int'(gnt), 1);
        tick();
        chk("sim_to_low2", int'(timeout), 0);
        req = 4'b0000;
        tick();
        chk("sim_release", int'(gnt), 0);

        // Grantee drops req in BUSY, then reset during BUSY.
        doReset();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0000;
        tick();
        chk("drop_gnt_held", int'(gnt), 4);
        resDone = 1'b1;
        tick();
        resDone = 1'b0;
        chk("drop_release_phase", int'(gnt), 4);
        tick();
        chk("drop_released", int'(gnt), 0);
        chk("drop_busy", int'(busy), 0);
        req = 4'b0100;
        tick();
        tick();
        chk("pre_rst_gnt", int'(gnt), 4);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", int'(gnt), 4);
        chk("post_rst_id", int'(gntId), 2);

        // Randomized traffic against the reference model.
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
                modelReset();
            end
            for (int b = 0; b < NREQ; b++) req[b] = ($urandom_range(0, 9) < 6);
            if ((cyc / 500) % 2 == 0) resDone = ($urandom_range(0, 2) == 0);
            else                      resDone = ($urandom_range(0, 24) == 0);
            modelStep(req, resDone);
            tick();
            modelCompare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- NREQ, 4, number of requesters, range 2..8.
- TIMEOUT, 16, maximum BUSY cycles before forced release, at least 1.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- req, in, NREQ, per-requester request, level-sensitive.
- gnt, out, NREQ, one-hot grant, registered.
- gnt_id, out, $clog2(NREQ), index of the current/last grantee, registered.
- res_start, out, 1, one-cycle start pulse to the shared resource.
- res_done, in, 1, resource completion, sampled only in BUSY.
- busy, out, 1, high whenever state is not IDLE.
- timeout, out, 1, one-cycle pulse when the watchdog expires.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, GRANT, BUSY, RELEASE; the encoding is free.
REQ-005 IDLE: when req is non-zero, the block SHALL select a winner round-robin, set gnt/gnt_id for the winner on the next edge, and enter GRANT.
REQ-006 Round-robin: search SHALL start at index (ptr+1) mod NREQ and ascend with wrap; ptr is the last released grantee.
REQ-007 The block SHALL have a latency of 1 cycle from req sampled high in IDLE to gnt high, and SHALL not grant when req is all-zero.
REQ-008 GRANT: the block SHALL assert res_start for exactly that one cycle, clear the watchdog count to 0, and enter BUSY.
REQ-009 BUSY, res_done=1: the block SHALL enter RELEASE.
REQ-010 BUSY, res_done=0: the count SHALL increment; when it reaches TIMEOUT-1 the block SHALL pulse timeout for one cycle and enter RELEASE.
REQ-011 BUSY, res_done=1 in the same cycle the count reaches TIMEOUT-1: res_done SHALL win and timeout SHALL stay low.
REQ-012 The watchdog count SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrapping.
REQ-013 RELEASE: gnt SHALL stay high until req[gnt_id]=0 is sampled; on that edge gnt clears, ptr is set to gnt_id, and the FSM enters IDLE.
REQ-014 If req[gnt_id] is already low on entry to RELEASE, release SHALL occur on the first RELEASE cycle.
REQ-015 The grantee dropping req in GRANT or BUSY SHALL be ignored; the grant is held until RELEASE completes.
REQ-016 Requests from non-granted requesters SHALL be ignored outside IDLE, with no queueing beyond the req level.
REQ-017 res_done outside BUSY SHALL be ignored.
REQ-018 gnt SHALL be one-hot or all-zero at all times; gnt_id SHALL retain its last value while gnt is zero.
REQ-019 IDLE with gnt zero: the block SHALL take at least one IDLE cycle between consecutive grants, so back-to-back grants are spaced by at least one gnt-low cycle.

Reset
REQ-020 While rst=1, the block SHALL hold: state=IDLE, gnt=0, gnt_id=0, res_start=0, busy=0, timeout=0, count=0, ptr=NREQ-1 (so the first search starts at index 0).
REQ-021 Reset asserted mid-operation, in any state, SHALL immediately clear every output with no release handshake; after deassertion the block resumes from IDLE on the next edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- NREQ=4, out of reset, req=4'b1010 -> gnt=4'b0010 one cycle later; res_start pulses on the next cycle; res_done=1 -> RELEASE; req[1] drops -> gnt=0, ptr=1.
- Round-robin: req=4'b1111 held, res_done returned 2 cycles after each res_start, each grantee drops req on release then re-asserts -> grant order 0,1,2,3,0.
- Timeout with TIMEOUT=16 and res_done never asserted -> timeout pulses exactly 16 cycles after the BUSY entry edge; gnt is still held until req drops.
- Simultaneous: res_done=1 on the final watchdog cycle -> timeout=0 and normal release.
- Grantee drops req during BUSY -> gnt stays 1; release occurs in the first RELEASE cycle after res_done.
- rst pulsed during BUSY with gnt=4'b0100 -> all outputs 0 asynchronously; after release, req=4'b0100 -> gnt=4'b0100 (ptr was reset to 3).
